// File: rtl/rv32_slice_alu_if.sv
// Request/response bundle between the operand muxes, the slice ALU and writeback.
interface rv32_slice_alu_if #(
    parameter int unsigned XLEN = 32
);
    logic            i_valid;
    logic            o_ready;
    logic [2:0]      i_op;
    logic [XLEN-1:0] i_operand_one;
    logic [XLEN-1:0] i_operand_two;
    logic            i_flush;
    logic            o_valid;
    logic            i_ready;
    logic [XLEN-1:0] o_result;
    logic            o_carry_out;
    logic            o_zero;

    modport master (
        output i_valid, i_op, i_operand_one, i_operand_two, i_flush, i_ready,
        input  o_ready, o_valid, o_result, o_carry_out, o_zero
    );

    modport slave (
        input  i_valid, i_op, i_operand_one, i_operand_two, i_flush, i_ready,
        output o_ready, o_valid, o_result, o_carry_out, o_zero
    );
endinterface

// File: rtl/rv32_slice_alu.sv
// Multicycle RV32 ALU processing SLICE_W bits per cycle with a registered carry chain.
// Supports add/sub, or/and/xor and signed/unsigned set-less-than with valid/ready and flush.
module rv32_slice_alu #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned SLICE_W = 16
) (
    input logic             i_clk,
    input logic             i_rst_n,
    rv32_slice_alu_if.slave bus
);
    localparam int unsigned NUM_SLICES = XLEN / SLICE_W;
    localparam int unsigned CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

    if ((XLEN % SLICE_W) != 0) begin : g_bad_slice
        $error("SLICE_W must divide XLEN");
    end

    localparam logic [2:0] OpOr   = 3'b001;
    localparam logic [2:0] OpAnd  = 3'b010;
    localparam logic [2:0] OpXor  = 3'b011;
    localparam logic [2:0] OpSub  = 3'b100;
    localparam logic [2:0] OpSltu = 3'b101;
    localparam logic [2:0] OpSlt  = 3'b110;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          state_q;
    logic [CNT_W-1:0] cnt_q;
    logic            carry_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic            a_msb_q;
    logic            b_msb_q;
    logic [2:0]      op_q;
    logic [XLEN-1:0] diff_q;
    logic [XLEN-1:0] res_q;
    logic            co_q;
    logic            valid_q;

    logic              is_logic;
    logic              is_invert;
    int unsigned       base;
    logic [SLICE_W:0]  sum_c;
    logic [SLICE_W-1:0] slice_res;
    logic [XLEN-1:0]   diff_full;
    logic [XLEN-1:0]   final_res;
    logic              final_co;
    logic              slt_bit;

    assign is_logic  = (op_q == OpOr) || (op_q == OpAnd) || (op_q == OpXor);
    assign is_invert = (bus.i_op == OpSub) || (bus.i_op == OpSltu) || (bus.i_op == OpSlt);

    always_comb begin
        base  = 32'(cnt_q) * SLICE_W;
        sum_c = {1'b0, a_q[base +: SLICE_W]} + {1'b0, b_q[base +: SLICE_W]}
              + (SLICE_W + 1)'(carry_q);
        unique case (op_q)
            OpOr:    slice_res = a_q[base +: SLICE_W] | b_q[base +: SLICE_W];
            OpAnd:   slice_res = a_q[base +: SLICE_W] & b_q[base +: SLICE_W];
            OpXor:   slice_res = a_q[base +: SLICE_W] ^ b_q[base +: SLICE_W];
            default: slice_res = sum_c[SLICE_W-1:0];
        endcase
        diff_full                   = diff_q;
        diff_full[base +: SLICE_W]  = slice_res;
        // Signs differ: A is less exactly when A is negative; otherwise the difference sign decides.
        slt_bit  = (a_msb_q ^ b_msb_q) ? a_msb_q : diff_full[XLEN-1];
        final_co = is_logic ? 1'b0 : sum_c[SLICE_W];
        unique case (op_q)
            OpSltu:  final_res = XLEN'(!sum_c[SLICE_W]);
            OpSlt:   final_res = XLEN'(slt_bit);
            default: final_res = diff_full;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            op_q    <= '0;
            diff_q  <= '0;
            res_q   <= '0;
            co_q    <= 1'b0;
            valid_q <= 1'b0;
        end else if (bus.i_flush) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.i_valid) begin
                        a_q     <= bus.i_operand_one;
                        b_q     <= is_invert ? ~bus.i_operand_two : bus.i_operand_two;
                        a_msb_q <= bus.i_operand_one[XLEN-1];
                        b_msb_q <= bus.i_operand_two[XLEN-1];
                        op_q    <= bus.i_op;
                        carry_q <= is_invert;
                        cnt_q   <= '0;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    diff_q  <= diff_full;
                    carry_q <= is_logic ? 1'b0 : sum_c[SLICE_W];
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(NUM_SLICES - 1)) begin
                        res_q   <= final_res;
                        co_q    <= final_co;
                        valid_q <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (bus.i_ready) begin
                        valid_q <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.o_ready     = (state_q == StIdle);
    assign bus.o_valid     = valid_q;
    assign bus.o_result    = res_q;
    assign bus.o_carry_out = co_q;
    assign bus.o_zero      = (res_q == '0);
endmodule

// File: tb/tb_rv32_slice_alu.sv
// Directed bench driving 16-, 8- and 32-bit-slice ALU instances with identical stimulus.
module tb_rv32_slice_alu;
    logic        clk;
    logic        rst_n;
    logic        t_valid;
    logic [2:0]  t_op;
    logic [31:0] t_a;
    logic [31:0] t_b;
    logic        t_flush;
    logic        t_ready;
    int          errors;
    int          checks;
    logic [31:0] lat16, lat8, lat32;
    logic [31:0] last_res;

    rv32_slice_alu_if #(.XLEN(32)) bus16 ();
    rv32_slice_alu_if #(.XLEN(32)) bus8 ();
    rv32_slice_alu_if #(.XLEN(32)) bus32 ();

    assign bus16.i_valid = t_valid;  assign bus8.i_valid = t_valid;  assign bus32.i_valid = t_valid;
    assign bus16.i_op    = t_op;     assign bus8.i_op    = t_op;     assign bus32.i_op    = t_op;
    assign bus16.i_operand_one = t_a; assign bus8.i_operand_one = t_a; assign bus32.i_operand_one = t_a;
    assign bus16.i_operand_two = t_b; assign bus8.i_operand_two = t_b; assign bus32.i_operand_two = t_b;
    assign bus16.i_flush = t_flush;  assign bus8.i_flush = t_flush;  assign bus32.i_flush = t_flush;
    assign bus16.i_ready = t_ready;  assign bus8.i_ready = t_ready;  assign bus32.i_ready = t_ready;

    rv32_slice_alu #(.XLEN(32), .SLICE_W(16)) dut16 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus16));
    rv32_slice_alu #(.XLEN(32), .SLICE_W(8))  dut8  (.i_clk(clk), .i_rst_n(rst_n), .bus(bus8));
    rv32_slice_alu #(.XLEN(32), .SLICE_W(32)) dut32 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus32));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation through all three instances; latency measured per instance, then released.
    task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er, input logic ec,
                       input logic ez);
        chk1({tag, " ready"}, bus16.o_ready, 1'b1);
        t_op = op; t_a = a; t_b = b; t_valid = 1'b1;
        tick();
        t_valid = 1'b0; t_a = ~a; t_b = a ^ b ^ 32'h1234_5678;
        lat16 = 0; lat8 = 0; lat32 = 0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (lat16 == 0 && bus16.o_valid) lat16 = c;
            if (lat8 == 0 && bus8.o_valid) lat8 = c;
            if (lat32 == 0 && bus32.o_valid) lat32 = c;
        end
        chk32({tag, " lat16"}, lat16, 32'd2);
        chk32({tag, " lat8"}, lat8, 32'd4);
        chk32({tag, " lat32"}, lat32, 32'd1);
        chk32({tag, " res16"}, bus16.o_result, er);
        chk32({tag, " res8"}, bus8.o_result, er);
        chk32({tag, " res32"}, bus32.o_result, er);
        chk1({tag, " co16"}, bus16.o_carry_out, ec);
        chk1({tag, " co8"}, bus8.o_carry_out, ec);
        chk1({tag, " co32"}, bus32.o_carry_out, ec);
        chk1({tag, " z16"}, bus16.o_zero, ez);
        chk1({tag, " z8"}, bus8.o_zero, ez);
        chk1({tag, " z32"}, bus32.o_zero, ez);
        t_ready = 1'b1;
        tick();
        t_ready = 1'b0;
        chk1({tag, " drop16"}, bus16.o_valid, 1'b0);
        chk1({tag, " drop8"}, bus8.o_valid, 1'b0);
        last_res = er;
    endtask

    initial begin
        errors = 0; checks = 0; last_res = '0;
        t_valid = 1'b0; t_op = 3'b000; t_a = '0; t_b = '0; t_flush = 1'b0; t_ready = 1'b0;
        rst_n = 1'b0;
        #12;
        chk1("rst ready", bus16.o_ready, 1'b1);
        chk1("rst valid", bus16.o_valid, 1'b0);
        chk32("rst result", bus16.o_result, 32'h0);
        chk1("rst carry", bus16.o_carry_out, 1'b0);
        chk1("rst zero", bus16.o_zero, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run("add_cross", 3'b000, 32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 1'b0, 1'b0);
        run("sub_eq",    3'b100, 32'd5, 32'd5, 32'h0, 1'b1, 1'b1);
        run("sub_borrow", 3'b100, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run("slt_neg",   3'b110, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b1, 1'b0);
        run("sltu_big",  3'b101, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b1);
        run("slt_min",   3'b110, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 1'b1, 1'b0);
        run("or",  3'b001, 32'hF0F0_A5A5, 32'h0FF0_FFFF, 32'hFFF0_FFFF, 1'b0, 1'b0);
        run("and", 3'b010, 32'hF0F0_A5A5, 32'h0FF0_FFFF, 32'h00F0_A5A5, 1'b0, 1'b0);
        run("xor", 3'b011, 32'hF0F0_A5A5, 32'h0FF0_FFFF, 32'hFF00_5A5A, 1'b0, 1'b0);
        run("rsvd_add", 3'b111, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0);
        run("add_wrap", 3'b000, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b1, 1'b1);

        // Backpressure: result must hold while new requests are presented and ignored.
        t_op = 3'b000; t_a = 32'h0000_FFFF; t_b = 32'h0000_0001; t_valid = 1'b1;
        tick();
        t_valid = 1'b0;
        tick();
        tick();
        for (int c = 0; c < 5; c++) begin
            t_valid = c[0]; t_op = 3'b011; t_a = 32'hDEAD_BEEF; t_b = 32'h0BAD_F00D;
            tick();
            chk1("bp valid", bus16.o_valid, 1'b1);
            chk1("bp ready", bus16.o_ready, 1'b0);
            chk32("bp result", bus16.o_result, 32'h0001_0000);
        end
        t_valid = 1'b0; t_ready = 1'b1;
        tick();
        t_ready = 1'b0;
        chk1("bp release", bus16.o_valid, 1'b0);
        for (int c = 0; c < 4; c++) tick();
        chk1("bp no accept16", bus16.o_valid, 1'b0);
        chk1("bp no accept8", bus8.o_valid, 1'b0);
        chk32("bp kept", bus16.o_result, 32'h0001_0000);
        last_res = 32'h0001_0000;

        // Flush one cycle into BUSY: no result, outputs keep previous value.
        t_op = 3'b000; t_a = 32'd7; t_b = 32'd9; t_valid = 1'b1;
        tick();
        t_valid = 1'b0; t_flush = 1'b1;
        tick();
        t_flush = 1'b0;
        chk1("fl ready", bus16.o_ready, 1'b1);
        chk1("fl valid32", bus32.o_valid, 1'b0);
        for (int c = 0; c < 5; c++) tick();
        chk1("fl valid16", bus16.o_valid, 1'b0);
        chk1("fl valid8", bus8.o_valid, 1'b0);
        chk32("fl keep16", bus16.o_result, last_res);
        chk32("fl keep8", bus8.o_result, last_res);
        run("post_flush", 3'b100, 32'd100, 32'd58, 32'd42, 1'b1, 1'b0);

        // Asynchronous reset mid-BUSY, checked between clock edges.
        t_op = 3'b011; t_a = 32'h1111_0000; t_b = 32'h0000_2222; t_valid = 1'b1;
        tick();
        t_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk1("ar ready", bus16.o_ready, 1'b1);
        chk1("ar valid", bus16.o_valid, 1'b0);
        chk32("ar result16", bus16.o_result, 32'h0);
        chk32("ar result8", bus8.o_result, 32'h0);
        chk1("ar carry", bus16.o_carry_out, 1'b0);
        chk1("ar zero", bus16.o_zero, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        chk1("ar idle valid", bus16.o_valid, 1'b0);
        run("post_rst", 3'b000, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
